// File: rtl/ps2_tx_pkg.sv
// Shared types and helpers for the PS/2 device-side keyboard transmitter.
package ps2_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GAP     = 2'd1,
        XFER    = 2'd2,
        INHIBIT = 2'd3
    } state_t;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Cycles at the start of every released half-period during which the
    // sensed clock is not trusted (two-flop synchroniser plus line rise).
    localparam int SETTLE = 4;

    // Number of bytes still to send in the current sequence (1..8).
    typedef logic [3:0] nbytes_t;

    // Odd parity bit: 1 when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~(^data);
    endfunction

    // Index of the highest non-zero byte plus one, never less than one.
    function automatic nbytes_t byte_count(input logic [63:0] word);
        nbytes_t n;
        n = 4'd1;
        for (int i = 1; i < 8; i++) begin
            if (word[8*i +: 8] != 8'h00) begin
                n = nbytes_t'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/ps2_tx_halftick.sv
// Half-period divider for the PS/2 transmitter: counts HALF cycles and
// pulses tick on the last one. restart zeroes the count so the following
// cycle is the first of a fresh half-period.
module ps2_tx_halftick #(
    parameter int HALF = 960,
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             restart,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo-HALF counter with synchronous restart.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick  = (cnt == LAST);
    assign count = cnt;

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 device-side keyboard transmitter. Watches the toggle bit of the
// 65-bit scancode word and replays its bytes (most significant non-zero
// byte first) as 11-bit PS/2 device frames on open-drain clock/data lines.
// One pending event is buffered; further events while it is full are
// dropped with an overflow pulse.
// Build option: define PS2_TX_INHIBIT_EN to honour host clock inhibit
// (abort the current byte, wait for the host to release, resend it).
module ps2_key_tx
    import ps2_tx_pkg::*;
#(
    parameter int CLK_HZ     = 24_000_000,
    parameter int PS2_HZ     = 12_500,
    parameter int GAP_HALVES = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic        ps2_clk_oe,
    output logic        ps2_dat_oe,
    output logic        busy,
    output logic        overflow
);

    localparam int HALF  = CLK_HZ / (2 * PS2_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [7:0] GAP_LAST = 8'(GAP_HALVES - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    // event detect
    logic        tog_p0;
    logic        tog_p1;
    logic        vld_p0;
    logic        vld_p1;
    logic [63:0] word_p0;
    logic        evt;

    // pending slot
    logic        slot_full;
    logic [63:0] slot_word;

    // transmit state
    state_t      state;
    state_t      state_nxt;
    logic [63:0] word_q;
    nbytes_t     n_q;
    logic [7:0]  gap_cnt;
    logic [3:0]  bit_cnt;
    logic        phase;
    logic        load;
    logic        restart;
    logic        byte_done;
    logic        tick;
    logic [CNT_W-1:0] half_cnt;

    logic [2:0]  byte_idx;
    logic [7:0]  cur_byte;
    logic        frame_bit;

    ps2_tx_halftick #(
        .HALF(HALF)
    ) u_halftick (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .restart(restart),
        .tick(tick),
        .count(half_cnt)
    );

`ifdef PS2_TX_INHIBIT_EN
    logic clk_s_p0;
    logic clk_s_p1;
    logic dat_s_p0;
    logic dat_s_p1;
    logic host_inhibit;
    logic unused_dat;

    // Two-flop synchronisers for the sensed lines; idle lines read high.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_s_p0 <= 1'b1;
            clk_s_p1 <= 1'b1;
            dat_s_p0 <= 1'b1;
            dat_s_p1 <= 1'b1;
        end else begin
            clk_s_p0 <= ps2_clk_in;
            clk_s_p1 <= clk_s_p0;
            dat_s_p0 <= ps2_dat_in;
            dat_s_p1 <= dat_s_p0;
        end
    end

    // Host holds the clock low while we have it released; the first cycles
    // of each half are blanked so our own just-released low is not mistaken.
    assign host_inhibit = !clk_s_p1 && !ps2_clk_oe && (half_cnt >= CNT_W'(SETTLE));
    assign unused_dat   = dat_s_p1;
`else
    logic unused_in;
    assign unused_in = ^{ps2_clk_in, ps2_dat_in, half_cnt};
`endif

    // Sample the toggle bit and word; the valid pair suppresses a false
    // event from the first sample after reset.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_p0 <= 1'b0;
            tog_p1 <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            tog_p0 <= ps2_key[64];
            tog_p1 <= tog_p0;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
        end
    end

    // Word sample travelling alongside the toggle sample.
    always_ff @(posedge clk_sys) begin
        word_p0 <= ps2_key[63:0];
    end

    assign evt = vld_p1 && (tog_p0 != tog_p1);

    // Slot occupancy and drop detection; a load in the same cycle frees
    // the slot for the incoming event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            slot_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= evt && slot_full && !load;
            if (evt && (!slot_full || load)) begin
                slot_full <= 1'b1;
            end else if (load) begin
                slot_full <= 1'b0;
            end
        end
    end

    // Slot and shifter word contents.
    always_ff @(posedge clk_sys) begin
        if (evt && (!slot_full || load)) begin
            slot_word <= word_p0;
        end
        if (load) begin
            word_q <= slot_word;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        restart   = 1'b0;
        byte_done = 1'b0;
        case (state)
            IDLE: begin
                if (slot_full) begin
                    load      = 1'b1;
                    restart   = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick && gap_cnt == GAP_LAST) begin
                    restart   = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (tick && phase && bit_cnt == LAST_BIT) begin
                    restart   = 1'b1;
                    byte_done = 1'b1;
                    state_nxt = (n_q == 4'd1) ? IDLE : GAP;
                end
            end
`ifdef PS2_TX_INHIBIT_EN
            INHIBIT: begin
                if (!clk_s_p1) begin
                    restart = 1'b1;
                end else if (tick) begin
                    restart   = 1'b1;
                    state_nxt = GAP;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef PS2_TX_INHIBIT_EN
        if ((state == GAP || state == XFER) && host_inhibit) begin
            restart   = 1'b1;
            byte_done = 1'b0;
            state_nxt = INHIBIT;
        end
`endif
    end

    // Byte count, gap half counter and bit/phase position; every state
    // entry restarts the position so a resent byte begins at its start bit.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            n_q     <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            if (load) begin
                n_q <= byte_count(slot_word);
            end else if (byte_done) begin
                n_q <= n_q - 4'd1;
            end
            if (restart) begin
                gap_cnt <= '0;
                bit_cnt <= '0;
                phase   <= 1'b0;
            end else if (tick) begin
                if (state == GAP) begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                if (state == XFER) begin
                    phase <= ~phase;
                    if (phase) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
            end
        end
    end

    assign byte_idx = 3'(n_q - 4'd1);
    assign cur_byte = word_q[{byte_idx, 3'b000} +: 8];

    // Frame bit for the current bit position.
    always_comb begin
        frame_bit = 1'b1;
        if (bit_cnt == 4'd0) begin
            frame_bit = 1'b0;
        end else if (bit_cnt <= 4'd8) begin
            frame_bit = cur_byte[3'(bit_cnt - 4'd1)];
        end else if (bit_cnt == 4'd9) begin
            frame_bit = odd_parity(cur_byte);
        end
    end

    // Decoded from reset-cleared registers, so reset releases the lines at once.
    assign ps2_clk_oe = (state == XFER) && phase;
    assign ps2_dat_oe = (state == XFER) && !frame_bit;
    assign busy       = (state != IDLE) || slot_full;

endmodule

// File: tb/tb_ps2_key_tx.sv
module tb_ps2_key_tx;

    localparam int CLK_HZ     = 1_000_000;
    localparam int PS2_HZ     = 50_000;
    localparam int GAP_HALVES = 4;
    localparam int HALF       = CLK_HZ / (2 * PS2_HZ);

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } exp_t;

    typedef struct {
        logic [63:0] word;
        int          n;
        logic [63:0] bytes;   // send order: first byte in [7:0]
        logic [7:0]  par;     // parity of byte i in bit i
    } vec_t;

    logic        clk_sys;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic        ps2_clk_in;
    logic        ps2_dat_in;
    logic        ps2_clk_oe;
    logic        ps2_dat_oe;
    logic        busy;
    logic        overflow;
    logic        host_hold;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];

    // monitor state
    int         mon_nbit = 0;
    logic       mon_prev = 1'b0;
    int         low_len = 0;
    int         idle_len = 0;
    int         low_bad = 0;
    int         hi_bad = 0;
    int         gap_bad = 0;
    int         aborts = 0;
    int         ov_cnt = 0;
    logic [10:0] frame;
    exp_t       mon_e;

    assign ps2_clk_in = ~(ps2_clk_oe | host_hold);
    assign ps2_dat_in = ~ps2_dat_oe;

    ps2_key_tx #(
        .CLK_HZ(CLK_HZ),
        .PS2_HZ(PS2_HZ),
        .GAP_HALVES(GAP_HALVES)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ps2_key(ps2_key),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .busy(busy),
        .overflow(overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Host-side frame decoder: samples data on each clock-low edge and
    // compares completed frames against the scoreboard.
    always @(negedge clk_sys) begin
        if (!reset_n) begin
            mon_nbit = 0;
            mon_prev = 1'b0;
            low_len  = 0;
            idle_len = 0;
        end else begin
            if (overflow) ov_cnt++;
            if (ps2_clk_oe) begin
                if (!mon_prev) begin
                    if (mon_nbit >= 1 && idle_len != HALF) hi_bad++;
                    if (mon_nbit == 0 && idle_len < (GAP_HALVES + 1) * HALF) gap_bad++;
                    frame[mon_nbit] = ~ps2_dat_oe;
                    mon_nbit++;
                    low_len = 0;
                end
                low_len++;
                idle_len = 0;
            end else begin
                if (mon_prev && low_len != HALF) low_bad++;
                idle_len++;
                if (mon_nbit > 0 && idle_len > 2 * HALF) begin
                    aborts++;
                    mon_nbit = 0;
                end
            end
            if (mon_nbit == 11) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got %0h, expected none", frame);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("frame", int'(frame), int'({1'b1, mon_e.par, mon_e.data, 1'b0}));
                end
                mon_nbit = 0;
            end
            mon_prev = ps2_clk_oe;
        end
    end

    task automatic send(input logic [63:0] w);
        @(posedge clk_sys);
        #1;
        ps2_key = {~ps2_key[64], w};
    endtask

    task automatic push(input logic [7:0] d, input logic p);
        exp_t e;
        e.data = d;
        e.par  = p;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        repeat (3) @(posedge clk_sys);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (busy && k < 20000);
        check({name, "_busy_drop"}, int'(busy), 0);
        check({name, "_queue"}, exp_q.size(), 0);
        repeat (12 * HALF) @(posedge clk_sys);
    endtask

    initial begin
        vec_t vecs[7];
        int   k;
        int   k_busy1;
        int   k_start;
        int   k_clk;
        int   ov_before;
        int   act;
        int   exp_aborts;

        vecs[0] = '{64'h1C,                  1, 64'h1C,                  8'b0000_0000};
        vecs[1] = '{64'hE0F075,              3, 64'h75F0E0,              8'b0000_0010};
        vecs[2] = '{64'h0,                   1, 64'h00,                  8'b0000_0001};
        vecs[3] = '{64'h12,                  1, 64'h12,                  8'b0000_0001};
        vecs[4] = '{64'hFF0000,              3, 64'h0000FF,              8'b0000_0111};
        vecs[5] = '{64'h8000_0000_0000_0001, 8, 64'h0100_0000_0000_0080, 8'b0111_1110};
        vecs[6] = '{64'hAA55,                2, 64'h55AA,                8'b0000_0011};

        exp_aborts = 0;
        reset_n   = 1'b0;
        ps2_key   = '0;
        host_hold = 1'b0;

        // reset state
        repeat (3) @(negedge clk_sys);
        check("rst_clk_oe", int'(ps2_clk_oe), 0);
        check("rst_dat_oe", int'(ps2_dat_oe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overflow", int'(overflow), 0);
        @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        repeat (5 * HALF) @(posedge clk_sys);

        // latency of the first frame
        push(8'h1C, 1'b0);
        send(64'h1C);
        k_busy1 = -1;
        k_start = -1;
        k_clk   = -1;
        k = 0;
        while (k < 3 + (GAP_HALVES + 2) * HALF && k_clk < 0) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            k++;
            if (k == 1) check("busy_t1", int'(busy), 0);
            if (busy && k_busy1 < 0) k_busy1 = k;
            if (ps2_dat_oe && k_start < 0) k_start = k;
            if (ps2_clk_oe && k_clk < 0) k_clk = k;
        end
        check("busy_latency", k_busy1, 2);
        check("start_latency", k_start, 3 + GAP_HALVES * HALF);
        check("clk_low_latency", k_clk, 3 + GAP_HALVES * HALF + HALF);
        wait_idle("latency");

        // table of words
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                push(vecs[i].bytes[8*j +: 8], vecs[i].par[j]);
            end
            send(vecs[i].word);
            wait_idle($sformatf("vec%0d", i));
        end

        // event detect coinciding with slot load: both sent, no drop
        ov_before = ov_cnt;
        push(8'h1C, 1'b0);
        push(8'h0F, 1'b1);
        send(64'h1C);
        send(64'h0F);
        wait_idle("simul");
        check("simul_no_overflow", ov_cnt - ov_before, 0);

        // three events within one frame: second queued, third dropped
        ov_before = ov_cnt;
        push(8'h1C, 1'b0);
        push(8'h5A, 1'b1);
        send(64'h1C);
        repeat (3 + GAP_HALVES * HALF + 3 * HALF) @(posedge clk_sys);
        check("ovf_in_xfer", int'(busy), 1);
        send(64'h5A);
        repeat (5) @(posedge clk_sys);
        send(64'h33);
        repeat (10) @(posedge clk_sys);
        check("ovf_pulse_once", ov_cnt - ov_before, 1);
        wait_idle("ovf");
        check("ovf_quiet_after", ov_cnt - ov_before, 1);

`ifdef PS2_TX_INHIBIT_EN
        // host inhibit during the frame: lines released, byte resent
        exp_aborts = 1;
        push(8'h1C, 1'b0);
        send(64'h1C);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!(mon_nbit == 5 && !ps2_clk_oe) && k < 2000);
        check("inh_reach_bit", int'(k < 2000), 1);
        host_hold = 1'b1;
        repeat (2 * HALF) @(negedge clk_sys);
        check("inh_clk_released", int'(ps2_clk_oe), 0);
        check("inh_dat_released", int'(ps2_dat_oe), 0);
        repeat (3 * HALF) @(negedge clk_sys);
        host_hold = 1'b0;
        wait_idle("inhibit");
`endif

        // asynchronous reset mid-frame
        push(8'h1C, 1'b0);
        send(64'h1C);
        k = 0;
        do begin
            @(negedge clk_sys);
            k++;
        end while (!ps2_clk_oe && k < 2000);
        check("rstmid_reach_pulse", int'(ps2_clk_oe && ps2_dat_oe), 1);
        reset_n = 1'b0;
        #1;
        check("rstmid_clk_oe", int'(ps2_clk_oe), 0);
        check("rstmid_dat_oe", int'(ps2_dat_oe), 0);
        check("rstmid_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        act = 0;
        repeat (30 * HALF) begin
            @(negedge clk_sys);
            if (ps2_clk_oe || ps2_dat_oe || busy) act++;
        end
        check("rstmid_no_replay", act, 0);

        // normal operation after reset
        push(8'hE0, 1'b0);
        send(64'hE0);
        wait_idle("post_reset");

        check("clk_low_len_bad", low_bad, 0);
        check("clk_high_len_bad", hi_bad, 0);
        check("gap_len_bad", gap_bad, 0);
        check("aborts", aborts, exp_aborts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
